// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controller state encoding and RV32I major opcodes.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic logic is_known_op(input logic [6:0] opcode);
      logic known;
      case (opcode)
         OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI,
         OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH: known = 1'b1;
         default:                                  known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing, PC update
// and a sticky trap state for illegal opcodes or misaligned redirects.
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   input  logic [6:0]  op,
   input  logic        branch_taken,
   input  logic [31:0] target,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_done,
   output logic        rf_we,
   output logic [31:0] pc,
   output logic [2:0]  state,
   output logic        trap
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        redirect_q, redirect_d;
   logic [31:0] target_q, target_d;
   logic        run_q;
   logic        go_fetch;

   // run_q keeps imem_req low while in reset and raises it on the first edge after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         ir_q       <= NOP_INSTR;
         redirect_q <= 1'b0;
         target_q   <= '0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         redirect_q <= redirect_d;
         target_q   <= target_d;
         run_q      <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      redirect_d = redirect_q;
      target_d   = target_q;
      go_fetch   = 1'b0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      trap       = 1'b0;

      case (state_q)
         ST_FETCH: begin
            imem_req = run_q;
            if (run_q && imem_valid) begin
               ir_d    = imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = is_known_op(op) ? ST_EXEC : ST_TRAP;
         end
         ST_EXEC: begin
            redirect_d = (op == OPC_JAL) || (op == OPC_JALR) ||
                         ((op == OPC_BRANCH) && branch_taken);
            target_d   = target;
            case (op)
               OPC_LOAD, OPC_STORE: state_d  = ST_MEM;
               OPC_BRANCH:          go_fetch = 1'b1;
               default:             state_d  = ST_WB;
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op == OPC_STORE);
            if (dmem_done) begin
               if (op == OPC_LOAD) state_d  = ST_WB;
               else                go_fetch = 1'b1;
            end
         end
         ST_WB: begin
            rf_we    = 1'b1;
            go_fetch = 1'b1;
         end
         ST_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_d = ST_TRAP;
         end
      endcase

      // A branch leaves EXEC on the same edge it latches, so the _d copies are used here
      if (go_fetch) begin
         if (redirect_d) begin
            if (target_d[1:0] != 2'b00) begin
               state_d = ST_TRAP;
            end else begin
               pc_d    = target_d;
               state_d = ST_FETCH;
            end
         end else begin
            pc_d    = pc_q + 32'd4;
            state_d = ST_FETCH;
         end
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; the decoder is modelled
// as op = ir[6:0] and memories are driven by hand.
module tb_multicycle_ctrl;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [31:0] ir;
   logic [6:0]  op;
   logic        branch_taken;
   logic [31:0] target;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_done;
   logic        rf_we;
   logic [31:0] pc;
   logic [2:0]  state;
   logic        trap;

   int errors = 0;
   int checks = 0;

   multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_valid   (imem_valid),
      .imem_rdata   (imem_rdata),
      .ir           (ir),
      .op           (op),
      .branch_taken (branch_taken),
      .target       (target),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_done    (dmem_done),
      .rf_we        (rf_we),
      .pc           (pc),
      .state        (state),
      .trap         (trap)
   );

   assign op = ir[6:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one instruction in FETCH after the given wait cycles; returns in DECODE
   task automatic applyStimulus(input logic [31:0] instr, input int waits);
      imem_rdata = instr;
      imem_valid = 1'b0;
      repeat (waits) tick();
      imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b1;
      imem_valid   = 1'b0;
      imem_rdata   = 32'h0;
      branch_taken = 1'b0;
      target       = 32'h0;
      dmem_done    = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("rst_state",    32'(state),    32'd0);
      checkOutput("rst_pc",       pc,            32'h0);
      checkOutput("rst_ir",       ir,            32'h0000_0013);
      checkOutput("rst_trap",     32'(trap),     32'd0);
      checkOutput("rst_rf_we",    32'(rf_we),    32'd0);
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
      checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
      #9 rst_n = 1'b1;
      tick();
      checkOutput("rel_imem_req", 32'(imem_req), 32'd1);
      checkOutput("rel_addr",     imem_addr,     32'h0);

      // ADDI with two fetch wait cycles
      imem_rdata = 32'h0050_0093;
      imem_valid = 1'b0;
      tick();
      checkOutput("addi_fetch2_state", 32'(state),    32'd0);
      checkOutput("addi_fetch2_req",   32'(imem_req), 32'd1);
      tick();
      checkOutput("addi_fetch3_state", 32'(state),    32'd0);
      imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      checkOutput("addi_decode_state", 32'(state), 32'd1);
      checkOutput("addi_ir",           ir,         32'h0050_0093);
      tick();
      checkOutput("addi_exec_state", 32'(state), 32'd2);
      checkOutput("addi_exec_rf_we", 32'(rf_we), 32'd0);
      tick();
      checkOutput("addi_wb_state", 32'(state), 32'd4);
      checkOutput("addi_wb_rf_we", 32'(rf_we), 32'd1);
      checkOutput("addi_wb_pc",    pc,         32'h0);
      tick();
      checkOutput("addi_done_state", 32'(state), 32'd0);
      checkOutput("addi_done_rf_we", 32'(rf_we), 32'd0);
      checkOutput("addi_done_pc",    pc,         32'h4);
      checkOutput("addi_done_addr",  imem_addr,  32'h4);

      // LW with a three-cycle data access; stray imem_valid must be ignored
      applyStimulus(32'h0000_A103, 0);
      tick();
      tick();
      imem_valid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      checkOutput("lw_mem1_state", 32'(state),    32'd3);
      checkOutput("lw_mem1_req",   32'(dmem_req), 32'd1);
      checkOutput("lw_mem1_we",    32'(dmem_we),  32'd0);
      tick();
      checkOutput("lw_mem2_req", 32'(dmem_req), 32'd1);
      tick();
      checkOutput("lw_mem3_req", 32'(dmem_req), 32'd1);
      checkOutput("lw_mem3_we",  32'(dmem_we),  32'd0);
      dmem_done = 1'b1;
      tick();
      dmem_done  = 1'b0;
      imem_valid = 1'b0;
      checkOutput("lw_wb_state", 32'(state),    32'd4);
      checkOutput("lw_wb_rf_we", 32'(rf_we),    32'd1);
      checkOutput("lw_wb_dreq",  32'(dmem_req), 32'd0);
      checkOutput("lw_wb_ir",    ir,            32'h0000_A103);
      tick();
      checkOutput("lw_done_state", 32'(state), 32'd0);
      checkOutput("lw_done_pc",    pc,         32'h8);

      // SW completing immediately
      applyStimulus(32'h0020_A023, 0);
      tick();
      tick();
      checkOutput("sw_mem_we",  32'(dmem_we),  32'd1);
      checkOutput("sw_mem_req", 32'(dmem_req), 32'd1);
      dmem_done = 1'b1;
      tick();
      dmem_done = 1'b0;
      checkOutput("sw_done_state", 32'(state), 32'd0);
      checkOutput("sw_done_rf_we", 32'(rf_we), 32'd0);
      checkOutput("sw_done_pc",    pc,         32'hC);

      // SW interrupted by reset in MEM
      applyStimulus(32'h0020_A023, 0);
      tick();
      tick();
      checkOutput("swrst_mem_req", 32'(dmem_req), 32'd1);
      #4 rst_n = 1'b0;
      #1;
      checkOutput("swrst_dreq",  32'(dmem_req), 32'd0);
      checkOutput("swrst_ireq",  32'(imem_req), 32'd0);
      checkOutput("swrst_state", 32'(state),    32'd0);
      checkOutput("swrst_pc",    pc,            32'h0);
      dmem_done = 1'b1;
      #2 rst_n = 1'b1;
      dmem_done = 1'b0;
      tick();
      checkOutput("swrst_rel_state", 32'(state),    32'd0);
      checkOutput("swrst_rel_ireq",  32'(imem_req), 32'd1);
      checkOutput("swrst_rel_pc",    pc,            32'h0);

      // BEQ taken to an aligned target
      applyStimulus(32'h0000_0063, 0);
      tick();
      branch_taken = 1'b1;
      target       = 32'h0000_0100;
      checkOutput("beq_exec_rf_we", 32'(rf_we),    32'd0);
      checkOutput("beq_exec_dreq",  32'(dmem_req), 32'd0);
      tick();
      branch_taken = 1'b0;
      target       = 32'h0;
      checkOutput("beq_next_state", 32'(state), 32'd0);
      checkOutput("beq_next_addr",  imem_addr,  32'h100);
      checkOutput("beq_next_rf_we", 32'(rf_we), 32'd0);

      // JAL to the top word of the address space
      applyStimulus(32'h0000_006F, 0);
      tick();
      target = 32'hFFFF_FFFC;
      tick();
      target = 32'h0;
      checkOutput("jal_wb_rf_we", 32'(rf_we), 32'd1);
      tick();
      checkOutput("jal_pc", pc, 32'hFFFF_FFFC);

      // ADDI at the last word wraps pc to zero
      applyStimulus(32'h0050_0093, 0);
      tick();
      tick();
      tick();
      checkOutput("wrap_pc", pc, 32'h0);

      // BEQ not taken falls through
      applyStimulus(32'h0000_0063, 0);
      tick();
      branch_taken = 1'b0;
      target       = 32'h0000_0200;
      tick();
      target = 32'h0;
      checkOutput("bnt_pc", pc, 32'h4);

      // BEQ taken to a misaligned target traps
      applyStimulus(32'h0000_0063, 0);
      tick();
      branch_taken = 1'b1;
      target       = 32'h0000_0102;
      tick();
      branch_taken = 1'b0;
      target       = 32'h0;
      checkOutput("mis_state", 32'(state),    32'd5);
      checkOutput("mis_trap",  32'(trap),     32'd1);
      checkOutput("mis_pc",    pc,            32'h4);
      checkOutput("mis_ireq",  32'(imem_req), 32'd0);

      #4 rst_n = 1'b0;
      #1;
      checkOutput("trap_rst_trap",  32'(trap),  32'd0);
      checkOutput("trap_rst_state", 32'(state), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      checkOutput("trap_rel_ireq", 32'(imem_req), 32'd1);

      // Illegal opcode traps after DECODE and stays there
      applyStimulus(32'h0000_007F, 0);
      tick();
      checkOutput("ill_state", 32'(state), 32'd5);
      checkOutput("ill_trap",  32'(trap),  32'd1);
      for (int i = 0; i < 20; i++) begin
         imem_valid = 1'b1;
         dmem_done  = 1'b1;
         tick();
         checkOutput("ill_hold_ireq", 32'(imem_req), 32'd0);
      end
      imem_valid = 1'b0;
      dmem_done  = 1'b0;
      checkOutput("ill_hold_state", 32'(state),    32'd5);
      checkOutput("ill_hold_pc",    pc,            32'h0);
      checkOutput("ill_hold_dreq",  32'(dmem_req), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
